// File: rtl/layer_seq.sv
// Per-run layer sequencer for the IFM write path: erase/load/compute per layer,
// with single-owner arbitration of the shared IFM write port.
module layer_seq #(
   parameter int DATA_SIZE = 16,
   parameter int MEM_SIZE  = 16,
   parameter int LAYER_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LAYER_W-1:0]   n_layer,
   input  logic                 skip_eras,
   output logic                 busy,
   output logic                 done,
   output logic [LAYER_W-1:0]   layer_idx,
   output logic                 err,
   output logic                 eras_en,
   output logic                 load_en,
   output logic                 comp_en,
   input  logic                 eras_done,
   input  logic                 load_done,
   input  logic                 comp_done,
   input  logic                 eras_we,
   input  logic [MEM_SIZE-1:0]  eras_wa,
   input  logic [DATA_SIZE-1:0] eras_wd,
   input  logic                 load_we,
   input  logic [MEM_SIZE-1:0]  load_wa,
   input  logic [DATA_SIZE-1:0] load_wd,
   input  logic                 comp_we,
   input  logic [MEM_SIZE-1:0]  comp_wa,
   input  logic [DATA_SIZE-1:0] comp_wd,
   output logic                 mem_we,
   output logic [MEM_SIZE-1:0]  mem_wa,
   output logic [DATA_SIZE-1:0] mem_wd
);

   localparam logic [3:0] IDLE = 4'd0;
   localparam logic [3:0] E_GO = 4'd1;
   localparam logic [3:0] E_LO = 4'd2;
   localparam logic [3:0] E_HI = 4'd3;
   localparam logic [3:0] L_GO = 4'd4;
   localparam logic [3:0] L_LO = 4'd5;
   localparam logic [3:0] L_HI = 4'd6;
   localparam logic [3:0] C_GO = 4'd7;
   localparam logic [3:0] C_LO = 4'd8;
   localparam logic [3:0] C_HI = 4'd9;
   localparam logic [3:0] NEXT = 4'd10;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_E    = 2'd1;
   localparam logic [1:0] OWN_L    = 2'd2;
   localparam logic [1:0] OWN_C    = 2'd3;

   logic [3:0]         state;
   logic [LAYER_W-1:0] n_layer_q;
   logic               skip_q;
   logic [1:0]         owner;
   logic               conflict;

   assign done    = (state == IDLE);
   assign busy    = (state != IDLE);
   assign eras_en = (state == E_GO);
   assign load_en = (state == L_GO);
   assign comp_en = (state == C_GO);

   always_comb begin
      owner = OWN_NONE;
      case (state)
         E_GO, E_LO, E_HI: owner = OWN_E;
         L_GO, L_LO, L_HI: owner = OWN_L;
         C_GO, C_LO, C_HI: owner = OWN_C;
         default:          owner = OWN_NONE;
      endcase
   end

   always_comb begin
      mem_we = 1'b0;
      mem_wa = '0;
      mem_wd = '0;
      case (owner)
         OWN_E: begin
            mem_we = eras_we;
            mem_wa = eras_wa;
            mem_wd = eras_wd;
         end
         OWN_L: begin
            mem_we = load_we;
            mem_wa = load_wa;
            mem_wd = load_wd;
         end
         OWN_C: begin
            mem_we = comp_we;
            mem_wa = comp_wa;
            mem_wd = comp_wd;
         end
         default: ;
      endcase
   end

   // With no owner (IDLE/NEXT) any write request is a conflict.
   assign conflict = (eras_we && (owner != OWN_E)) ||
                     (load_we && (owner != OWN_L)) ||
                     (comp_we && (owner != OWN_C));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         layer_idx <= '0;
         n_layer_q <= '0;
         skip_q    <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (conflict)
            err <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  err <= 1'b0;
                  if (n_layer != '0) begin
                     n_layer_q <= n_layer;
                     skip_q    <= skip_eras;
                     layer_idx <= '0;
                     state     <= skip_eras ? L_GO : E_GO;
                  end
               end
            end
            E_GO: state <= E_LO;
            E_LO: if (!eras_done) state <= E_HI;
            E_HI: if (eras_done)  state <= L_GO;
            L_GO: state <= L_LO;
            L_LO: if (!load_done) state <= L_HI;
            L_HI: if (load_done)  state <= C_GO;
            C_GO: state <= C_LO;
            C_LO: if (!comp_done) state <= C_HI;
            C_HI: if (comp_done)  state <= NEXT;
            NEXT: begin
               if (layer_idx == n_layer_q - LAYER_W'(1)) begin
                  state <= IDLE;
               end else begin
                  layer_idx <= layer_idx + LAYER_W'(1);
                  state     <= skip_q ? L_GO : E_GO;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
